counter_cmd_sequencer: RTL and testbench

COUNTER_CMD_SEQUENCER -- requirements
Module: counter_cmd_sequencer

---
 rtl/counter_cmd_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_counter_cmd_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_cmd_sequencer.sv
// counter_cmd_sequencer: queues host commands in a 4-deep FIFO and applies them
// one at a time to an 8-bit counter (CLEAR / ADD / SUB / WAIT n ticks).
// Ports:
//   sys_clk, reset         clock and synchronous active-high reset
//   cmd_valid/op/arg       host command; accepted when cmd_ready is high
//   cmd_ready              FIFO has room and no abort in progress
//   abort                  flush FIFO, drop the current command, hold count
//   count                  sequenced counter value
//   busy                   command in flight or FIFO non-empty
//   done, wrap             one-cycle completion / carry-borrow pulses
//   level                  FIFO occupancy 0..4
module counter_cmd_sequencer #(
  parameter logic [23:0] DIV = 24'h100000
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_arg,
  output logic       cmd_ready,
  input  logic       abort,
  output logic [7:0] count,
  output logic       busy,
  output logic       done,
  output logic       wrap,
  output logic [2:0] level
);

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned LVL_W = 3;
  localparam int unsigned ARG_W = 8;
  localparam int unsigned PRE_W = 24;

  localparam logic [1:0] OP_CLEAR = 2'd0;
  localparam logic [1:0] OP_ADD   = 2'd1;
  localparam logic [1:0] OP_SUB   = 2'd2;
  localparam logic [1:0] OP_WAIT  = 2'd3;

  typedef struct packed {
    logic [1:0]       op;
    logic [ARG_W-1:0] arg;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  cmd_t               fifo_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LVL_W-1:0]   level_q;
  cmd_t               cmd_q;
  logic [ARG_W-1:0]   count_q, count_d;
  logic [ARG_W-1:0]   wait_q, wait_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;
  logic [PRE_W-1:0]   pre_cnt;
  logic               tick;
  logic               push, pop;
  logic [ARG_W:0]     add_sum;

  // Handshake: abort blocks new pushes in the same cycle it flushes the queue.
  assign cmd_ready = (level_q < LVL_W'(DEPTH)) && !abort;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == ST_IDLE) && (level_q != '0) && !abort;
  assign tick      = (pre_cnt == (DIV - 24'd1));
  assign add_sum   = {1'b0, count_q} + {1'b0, cmd_q.arg};

  assign count = count_q;
  assign done  = done_q;
  assign wrap  = wrap_q;
  assign level = level_q;
  assign busy  = (state_q != ST_IDLE) || (level_q != '0);

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cmd_op, cmd_arg};
    end
  end

  // Next-state and datapath decode.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wait_d  = wait_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (level_q != '0) state_d = ST_EXEC;
        end
        ST_EXEC: begin
          case (cmd_q.op)
            OP_CLEAR: begin
              count_d = '0;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
            OP_ADD: begin
              count_d = add_sum[ARG_W-1:0];
              wrap_d  = add_sum[ARG_W];
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
            OP_SUB: begin
              count_d = count_q - cmd_q.arg;
              wrap_d  = (cmd_q.arg > count_q);
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
            OP_WAIT: begin
              if (cmd_q.arg == '0) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end else begin
                wait_d  = cmd_q.arg;
                state_d = ST_WAIT;
              end
            end
            default: state_d = ST_IDLE;
          endcase
        end
        ST_WAIT: begin
          if (tick) begin
            wait_d = wait_q - ARG_W'(1);
            // Last tick: counter reaches zero on this edge.
            if (wait_q == ARG_W'(1)) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State register plus FIFO pointers, counters and output pulses.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      wait_q  <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      cmd_q   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      pre_cnt <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
      if (abort) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        level_q <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop) begin
          cmd_q  <= fifo_mem[rd_ptr];
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        case ({push, pop})
          2'b10:   level_q <= level_q + LVL_W'(1);
          2'b01:   level_q <= level_q - LVL_W'(1);
          default: level_q <= level_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Scoreboard bench for counter_cmd_sequencer: accepted commands are run through
// an arithmetic model and their expected (count, wrap) pushed to a queue; a
// monitor pops one entry per done pulse.
module tb_counter_cmd_sequencer;

  localparam logic [23:0] DIV   = 24'd4;
  localparam int          DIV_I = 4;

  logic       sys_clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_arg = 8'd0;
  logic       abort = 1'b0;
  logic       cmd_ready, busy, done, wrap;
  logic [7:0] count;
  logic [2:0] level;

  counter_cmd_sequencer #(.DIV(DIV)) dut (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_op   (cmd_op),
    .cmd_arg  (cmd_arg),
    .cmd_ready(cmd_ready),
    .abort    (abort),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap),
    .level    (level)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int cnt;
    bit wr;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_rst = 0;
  int   last_acc = 0;
  int   model_count = 0;
  int   mon_last = 0;
  bit   prev_done = 1'b0;
  exp_t exp_q[$];
  int   done_edges[$];

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, cyc);
    end
  endtask

  // Edge counter; remembers the last edge sampled in reset for tick phase.
  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    if (reset) last_rst <= cyc + 1;
  end

  function automatic bit is_tick(input int e);
    int rc;
    rc = e - last_rst;
    return (rc > 0) && (rc % DIV_I == 0);
  endfunction

  // Reference model: command semantics in plain integer arithmetic.
  task automatic model_accept(input logic [1:0] op, input logic [7:0] arg);
    exp_t e;
    int a;
    a = int'(arg);
    e.wr = 1'b0;
    case (op)
      2'd0: model_count = 0;
      2'd1: begin
        e.wr = (model_count + a) >= 256;
        model_count = (model_count + a) % 256;
      end
      2'd2: begin
        e.wr = a > model_count;
        model_count = (model_count - a + 256) % 256;
      end
      default: ;
    endcase
    e.cnt = model_count;
    exp_q.push_back(e);
  endtask

  // Commands not yet completed are lost; count falls back to the last completion.
  task automatic flush_model(input bit to_zero);
    exp_q.delete();
    if (to_zero) mon_last = 0;
    model_count = mon_last;
  endtask

  // Monitor: one scoreboard entry per done pulse.
  always @(negedge sys_clk) begin
    exp_t e;
    if (!reset) begin
      if (wrap) check("wrap_with_done", int'(done), 1);
      if (done) begin
        check("done_not_consecutive", int'(prev_done), 0);
        check("sb_nonempty", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sb_count", int'(count), e.cnt);
          check("sb_wrap", int'(wrap), int'(e.wr));
          mon_last = e.cnt;
          done_edges.push_back(cyc);
        end
      end
    end
    prev_done = done;
  end

  task automatic send(input logic [1:0] op, input logic [7:0] arg);
    int guard;
    guard = 0;
    @(negedge sys_clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    while (!cmd_ready && guard < 2000) begin
      @(negedge sys_clk);
      guard++;
    end
    if (!cmd_ready) begin
      check("send_accept", int'(cmd_ready), 1);
      cmd_valid = 1'b0;
      return;
    end
    model_accept(op, arg);
    @(posedge sys_clk);
    #1;
    last_acc  = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge sys_clk);
    while ((busy || exp_q.size() != 0) && guard < 1000) begin
      @(negedge sys_clk);
      guard++;
    end
    check("idle_reached", int'(busy), 0);
  endtask

  task automatic do_abort();
    @(negedge sys_clk);
    abort = 1'b1;
    @(posedge sys_clk);
    #1;
    abort = 1'b0;
    flush_model(1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a_edge, t, n, got, acc, held;
    bit busy_ok, cnt_ok;
    logic [1:0] op;
    logic [7:0] arg;

    // Reset values
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    reset = 1'b0;
    check("rst_count", int'(count), 0);
    check("rst_level", int'(level), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_wrap", int'(wrap), 0);
    check("rst_ready", int'(cmd_ready), 1);

    // Back-to-back ADD 5, ADD 3, SUB 2: completions at N+2, N+4, N+6
    done_edges.delete();
    send(2'd1, 8'd5);
    a_edge = last_acc;
    send(2'd1, 8'd3);
    send(2'd2, 8'd2);
    wait_idle();
    check("b2b_done_count", done_edges.size(), 3);
    if (done_edges.size() == 3) begin
      check("b2b_lat0", done_edges[0] - a_edge, 2);
      check("b2b_lat1", done_edges[1] - a_edge, 4);
      check("b2b_lat2", done_edges[2] - a_edge, 6);
    end

    // Carry and borrow around 250 + 10, then 4 - 5
    send(2'd0, 8'd0);
    send(2'd1, 8'd250);
    send(2'd1, 8'd10);
    send(2'd2, 8'd5);
    wait_idle();
    check("wrap_final_count", int'(count), 255);

    // WAIT 3 with DIV 4: done on the third tick after EXEC
    held = model_count;
    send(2'd3, 8'd3);
    a_edge = last_acc;
    t = a_edge + 2;
    n = 0;
    while (n < 3) begin
      t++;
      if (is_tick(t)) n++;
    end
    busy_ok = 1'b1;
    cnt_ok  = 1'b1;
    got = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge sys_clk);
      if (done) begin
        got = cyc;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (int'(count) != held) cnt_ok = 1'b0;
    end
    check("wait_done_edge", got, t);
    check("wait_busy_high", int'(busy_ok), 1);
    check("wait_count_held", int'(cnt_ok), 1);
    check("wait_count_after", int'(count), held);
    wait_idle();

    // Hold cmd_valid 6 cycles during a WAIT: exactly 4 accepted
    send(2'd3, 8'd5);
    repeat (3) @(negedge sys_clk);
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge sys_clk);
      cmd_valid = 1'b1;
      cmd_op    = 2'd1;
      cmd_arg   = 8'(10 + i);
      if (cmd_ready) begin
        model_accept(cmd_op, cmd_arg);
        acc++;
      end
      @(posedge sys_clk);
    end
    #1 cmd_valid = 1'b0;
    @(negedge sys_clk);
    check("full_accepted", acc, 4);
    check("full_level", int'(level), 4);
    check("full_ready", int'(cmd_ready), 0);
    wait_idle();

    // Abort during WAIT with 3 queued
    send(2'd3, 8'd10);
    send(2'd1, 8'd1);
    send(2'd1, 8'd2);
    send(2'd2, 8'd3);
    @(negedge sys_clk);
    check("abort_pre_level", int'(level), 3);
    do_abort();
    @(negedge sys_clk);
    check("abort_level", int'(level), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_count", int'(count), model_count);
    repeat (60) @(negedge sys_clk);
    check("abort_count_later", int'(count), model_count);

    // Reset during WAIT with 2 queued
    send(2'd3, 8'd10);
    send(2'd1, 8'd7);
    send(2'd1, 8'd9);
    @(negedge sys_clk);
    reset = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1 flush_model(1'b1);
    check("mid_rst_count", int'(count), 0);
    check("mid_rst_level", int'(level), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_wrap", int'(wrap), 0);
    @(negedge sys_clk);
    reset = 1'b0;
    @(negedge sys_clk);
    check("mid_rst_ready", int'(cmd_ready), 1);
    send(2'd1, 8'd1);
    wait_idle();
    check("post_rst_add", int'(count), 1);

    // Randomized traffic with occasional aborts
    for (int it = 0; it < 300; it++) begin
      n = int'($urandom_range(0, 19));
      if (n == 0) begin
        do_abort();
      end else if (n < 4) begin
        @(negedge sys_clk);
      end else begin
        op  = 2'($urandom_range(0, 3));
        arg = (op == 2'd3) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
        send(op, arg);
      end
    end
    wait_idle();
    check("rand_final_count", int'(count), model_count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
